// File: rtl/seg7_scan_decoder_pkg.sv
// Shared 7-segment glyph table (active-low, bit0=a .. bit6=g) and scan FSM states.
// The hex-to-7-seg encoder imports the same constants so both ends stay in step.
package seg7_scan_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_HOLD} state_e;

endpackage

// File: rtl/seg7_scan_decoder_to_hex.sv
// Combinational glyph decoder: active-low segment pattern -> hex value plus blank/illegal flags.
module seg7_to_hex
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] value_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    value_o = 4'h0;
    blank_o = 1'b0;
    err_o   = 1'b0;
    case (pat_i)
      SEG_0:     value_o = 4'h0;
      SEG_1:     value_o = 4'h1;
      SEG_2:     value_o = 4'h2;
      SEG_3:     value_o = 4'h3;
      SEG_4:     value_o = 4'h4;
      SEG_5:     value_o = 4'h5;
      SEG_6:     value_o = 4'h6;
      SEG_7:     value_o = 4'h7;
      SEG_8:     value_o = 4'h8;
      SEG_9:     value_o = 4'h9;
      SEG_A:     value_o = 4'hA;
      SEG_B:     value_o = 4'hB;
      SEG_C:     value_o = 4'hC;
      SEG_D:     value_o = 4'hD;
      SEG_E:     value_o = 4'hE;
      SEG_F:     value_o = 4'hF;
      SEG_BLANK: blank_o = 1'b1;
      default:   err_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops multiplexed 7-segment lines, qualifies each digit over STABLE_CYC synced cycles,
// and publishes one decoded frame per complete scan; flags stalls when the scan stops.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int N_DIG       = 2,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [6:0]           i_seg,
  input  logic [N_DIG-1:0]     i_an,
  output logic [4*N_DIG-1:0]   o_value,
  output logic [N_DIG-1:0]     o_blank,
  output logic                 o_err,
  output logic                 o_valid,
  output logic                 o_stall
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int DW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  logic [6:0]            seg_s1_q, seg_s2_q;
  logic [N_DIG-1:0]      an_s1_q, an_s2_q;
  logic [N_DIG-1:0]      sel;
  logic                  sel_vld, same, cap, frame, timeout;
  logic [DW-1:0]         idx, d_q, d_d;
  logic [6:0]            pat_q, pat_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         stall_q, stall_d;
  state_e                state_q, state_d;

  logic [N_DIG-1:0][3:0] stage_q, stage_d, value_q;
  logic [N_DIG-1:0]      blank_stg_q, blank_stg_d, err_stg_q, err_stg_d, mask_q, mask_d;
  logic [N_DIG-1:0]      blank_q;
  logic                  err_q, valid_q;
  logic [3:0]            dec_value;
  logic                  dec_blank, dec_err;

  // The recorded pattern equals the live one whenever a capture fires, so decode the register.
  seg7_to_hex u_dec (
    .pat_i   (pat_q),
    .value_o (dec_value),
    .blank_o (dec_blank),
    .err_o   (dec_err)
  );

  assign sel     = ~an_s2_q;
  assign sel_vld = ($countones(sel) == 1);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N_DIG; i++)
      if (sel[i]) idx = DW'(i);
  end

  assign same = (idx == d_q) && (seg_s2_q == pat_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    pat_d   = pat_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          state_d = S_QUAL;
          cnt_d   = CW'(1);
          d_d     = idx;
          pat_d   = seg_s2_q;
        end
      end
      S_QUAL: begin
        if (!sel_vld) begin
          state_d = S_IDLE;
        end else if (same) begin
          if (cnt_q == CW'(STABLE_CYC - 1)) begin
            cap     = 1'b1;
            state_d = S_HOLD;
            cnt_d   = CW'(STABLE_CYC);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = CW'(1);
          d_d   = idx;
          pat_d = seg_s2_q;
        end
      end
      S_HOLD: begin
        if (!sel_vld) begin
          state_d = S_IDLE;
        end else if (!same) begin
          state_d = S_QUAL;
          cnt_d   = CW'(1);
          d_d     = idx;
          pat_d   = seg_s2_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_stall = (stall_q == TW'(TIMEOUT_CYC));
  assign stall_d = cap ? '0 : (o_stall ? stall_q : stall_q + TW'(1));
  assign timeout = (stall_d == TW'(TIMEOUT_CYC));
  assign frame   = &mask_q;

  // A stalled scan drops any partially assembled frame.
  always_comb begin
    stage_d     = stage_q;
    blank_stg_d = blank_stg_q;
    err_stg_d   = err_stg_q;
    mask_d      = mask_q;
    if (frame || timeout) mask_d = '0;
    if (frame) err_stg_d = '0;
    if (cap) begin
      stage_d[d_q]     = dec_value;
      blank_stg_d[d_q] = dec_blank;
      err_stg_d[d_q]   = dec_err;
      mask_d[d_q]      = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_s1_q    <= '1;
      seg_s2_q    <= '1;
      an_s1_q     <= '1;
      an_s2_q     <= '1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      d_q         <= '0;
      pat_q       <= '0;
      stall_q     <= '0;
      stage_q     <= '0;
      blank_stg_q <= '0;
      err_stg_q   <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      blank_q     <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      seg_s1_q    <= i_seg;
      seg_s2_q    <= seg_s1_q;
      an_s1_q     <= i_an;
      an_s2_q     <= an_s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      pat_q       <= pat_d;
      stall_q     <= stall_d;
      stage_q     <= stage_d;
      blank_stg_q <= blank_stg_d;
      err_stg_q   <= err_stg_d;
      mask_q      <= mask_d;
      valid_q     <= frame;
      if (frame) begin
        value_q <= stage_q;
        blank_q <= blank_stg_q;
        err_q   <= |err_stg_q;
      end
    end
  end

  assign o_value = value_q;
  assign o_blank = blank_q;
  assign o_err   = err_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: two digits, 4-cycle qualification, 16-cycle stall timeout.
module tb_seg7_scan_decoder;
  import seg7_scan_decoder_pkg::*;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic [6:0] i_seg;
  logic [1:0] i_an;
  logic [7:0] o_value;
  logic [1:0] o_blank;
  logic       o_err, o_valid, o_stall;

  int         tests = 0;
  int         fails = 0;
  int         vcnt  = 0;
  logic [7:0] last_val   = '0;
  logic [1:0] last_blank = '0;
  logic       last_err   = 1'b0;

  seg7_scan_decoder #(.N_DIG(2), .STABLE_CYC(4), .TIMEOUT_CYC(16)) dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_seg   (i_seg),
    .i_an    (i_an),
    .o_value (o_value),
    .o_blank (o_blank),
    .o_err   (o_err),
    .o_valid (o_valid),
    .o_stall (o_stall)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid) begin
      vcnt++;
      last_val   = o_value;
      last_blank = o_blank;
      last_err   = o_err;
    end
  end

  task automatic hold(input logic [1:0] an, input logic [6:0] seg, input int n);
    i_an  = an;
    i_seg = seg;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    i_an    = 2'b11;
    i_seg   = SEG_BLANK;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({o_value, o_blank, o_err, o_valid, o_stall} !== 13'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {o_value, o_blank, o_err, o_valid, o_stall});
    end
    i_rst_n = 1'b1;
    hold(2'b11, SEG_BLANK, 2);
  endtask

  task automatic test_basic;
    int v0;
    v0 = vcnt;
    hold(2'b10, SEG_5, 8);
    hold(2'b01, SEG_A, 8);
    hold(2'b11, SEG_BLANK, 3);
    tests++;
    if (vcnt - v0 !== 1) begin
      fails++;
      $display("FAIL basic_valid_count: got %0d expected 1", vcnt - v0);
    end
    tests++;
    if ({last_val, last_blank, last_err} !== {8'hA5, 2'b00, 1'b0}) begin
      fails++;
      $display("FAIL basic_frame: got val=%h blank=%b err=%b expected val=a5 blank=00 err=0",
               last_val, last_blank, last_err);
    end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vcnt;
    hold(2'b10, SEG_3, 3);
    hold(2'b01, SEG_8, 8);
    tests++;
    if (vcnt !== v0) begin
      fails++;
      $display("FAIL glitch_no_frame: got %0d frames expected 0", vcnt - v0);
    end
    hold(2'b10, SEG_2, 8);
    hold(2'b11, SEG_BLANK, 3);
    tests++;
    if (vcnt - v0 !== 1 || last_val !== 8'h82) begin
      fails++;
      $display("FAIL glitch_frame: got count=%0d val=%h expected count=1 val=82", vcnt - v0, last_val);
    end
  endtask

  task automatic test_illegal_blank;
    int v0;
    v0 = vcnt;
    hold(2'b10, 7'h7E, 8);
    hold(2'b01, SEG_BLANK, 8);
    hold(2'b11, SEG_BLANK, 3);
    tests++;
    if (vcnt - v0 !== 1) begin
      fails++;
      $display("FAIL illegal_valid_count: got %0d expected 1", vcnt - v0);
    end
    tests++;
    if ({last_val, last_blank, last_err} !== {8'h00, 2'b10, 1'b1}) begin
      fails++;
      $display("FAIL illegal_frame: got val=%h blank=%b err=%b expected val=00 blank=10 err=1",
               last_val, last_blank, last_err);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = vcnt;
    hold(2'b10, SEG_F, 8);
    hold(2'b01, SEG_C, 8);
    tests++;
    if (vcnt - v0 !== 1 || {last_val, last_blank, last_err} !== {8'hCF, 2'b00, 1'b0}) begin
      fails++;
      $display("FAIL b2b_first: got count=%0d val=%h blank=%b err=%b expected count=1 val=cf blank=00 err=0",
               vcnt - v0, last_val, last_blank, last_err);
    end
    hold(2'b10, SEG_0, 8);
    hold(2'b01, SEG_9, 8);
    hold(2'b11, SEG_BLANK, 3);
    tests++;
    if (vcnt - v0 !== 2 || {last_val, last_err} !== {8'h90, 1'b0}) begin
      fails++;
      $display("FAIL b2b_second: got count=%0d val=%h err=%b expected count=2 val=90 err=0",
               vcnt - v0, last_val, last_err);
    end
  endtask

  task automatic test_invalid_sel;
    int v0;
    v0 = vcnt;
    hold(2'b00, SEG_1, 20);
    hold(2'b11, SEG_1, 20);
    tests++;
    if (vcnt !== v0) begin
      fails++;
      $display("FAIL invalid_sel_no_frame: got %0d frames expected 0", vcnt - v0);
    end
    tests++;
    if (o_value !== 8'h90) begin
      fails++;
      $display("FAIL invalid_sel_hold: got %h expected 90", o_value);
    end
    tests++;
    if (o_stall !== 1'b1) begin
      fails++;
      $display("FAIL invalid_sel_stall: got %b expected 1", o_stall);
    end
  endtask

  task automatic test_stall;
    int v0;
    hold(2'b10, SEG_2, 8);
    tests++;
    if (o_stall !== 1'b0) begin
      fails++;
      $display("FAIL stall_clear_on_capture: got %b expected 0", o_stall);
    end
    hold(2'b11, SEG_BLANK, 13);
    tests++;
    if (o_stall !== 1'b0) begin
      fails++;
      $display("FAIL stall_early: got %b expected 0 at 15 idle cycles", o_stall);
    end
    hold(2'b11, SEG_BLANK, 1);
    tests++;
    if (o_stall !== 1'b1) begin
      fails++;
      $display("FAIL stall_at_timeout: got %b expected 1 at 16 idle cycles", o_stall);
    end
    v0 = vcnt;
    hold(2'b01, SEG_9, 8);
    tests++;
    if (o_stall !== 1'b0 || vcnt !== v0) begin
      fails++;
      $display("FAIL stall_partial_dropped: got stall=%b frames=%0d expected stall=0 frames=0",
               o_stall, vcnt - v0);
    end
    hold(2'b10, SEG_4, 8);
    hold(2'b11, SEG_BLANK, 3);
    tests++;
    if (vcnt - v0 !== 1 || last_val !== 8'h94) begin
      fails++;
      $display("FAIL stall_recover_frame: got count=%0d val=%h expected count=1 val=94", vcnt - v0, last_val);
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    hold(2'b10, SEG_7, 8);
    #3;
    i_rst_n = 1'b0;
    #1;
    tests++;
    if ({o_value, o_blank, o_err, o_valid, o_stall} !== 13'h0) begin
      fails++;
      $display("FAIL reset_async_outputs: got %h expected 0", {o_value, o_blank, o_err, o_valid, o_stall});
    end
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    v0 = vcnt;
    hold(2'b01, SEG_6, 8);
    tests++;
    if (vcnt !== v0) begin
      fails++;
      $display("FAIL reset_no_stale_digit: got %0d frames expected 0", vcnt - v0);
    end
    hold(2'b10, SEG_E, 8);
    hold(2'b11, SEG_BLANK, 3);
    tests++;
    if (vcnt - v0 !== 1 || {last_val, last_err} !== {8'h6E, 1'b0}) begin
      fails++;
      $display("FAIL reset_frame: got count=%0d val=%h err=%b expected count=1 val=6e err=0",
               vcnt - v0, last_val, last_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_illegal_blank();
    test_back_to_back();
    test_invalid_sel();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
